// File: rtl/dbg_bridge_pkg.sv
// Shared constants and state encodings for the UART debug bridge.
// Holds the host command codes, the response code and the frame/bit-engine FSM encodings.
package dbg_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_READ  = 8'h5A;
  localparam logic [7:0] ACK_CODE  = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_BUS   = 3'd3,
    ST_RESP  = 3'd4
  } bridge_state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Little-endian byte lane select of a 32-bit word.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dbg_uart_phy.sv
// 8N1 UART bit engines for the debug bridge: RX byte/valid/stop-error and TX byte/ready.
// TX accepts the next byte on the last cycle of a stop bit so consecutive bytes are gapless.
module dbg_uart_phy
  import dbg_bridge_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done
);

  localparam logic [15:0] FULL_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'((BAUD_DIV / 2) - 1);

  logic [1:0]  rx_sync_r;
  rx_state_e   rx_state_r;
  rx_state_e   rx_state_nxt_s;
  logic [15:0] rx_cnt_r;
  logic [2:0]  rx_bit_r;
  logic [7:0]  rx_shift_r;
  logic        rx_valid_r;
  logic        rx_err_r;
  logic        rx_line_s;
  logic        rx_half_hit_s;
  logic        rx_full_hit_s;

  tx_state_e   tx_state_r;
  tx_state_e   tx_state_nxt_s;
  logic [15:0] tx_cnt_r;
  logic [3:0]  tx_bit_r;
  logic [8:0]  tx_shift_r;
  logic        ser_tx_r;
  logic        tx_full_hit_s;
  logic        tx_end_s;
  logic        tx_ready_s;
  logic        tx_load_s;

  assign rx_line_s     = rx_sync_r[1];
  assign rx_half_hit_s = (rx_cnt_r == HALF_LAST);
  assign rx_full_hit_s = (rx_cnt_r == FULL_LAST);

  assign tx_full_hit_s = (tx_cnt_r == FULL_LAST);
  assign tx_end_s      = (tx_state_r == TX_SEND) && tx_full_hit_s && (tx_bit_r == 4'd9);
  assign tx_ready_s    = (tx_state_r == TX_IDLE) || tx_end_s;
  assign tx_load_s     = tx_valid && tx_ready_s;

  assign rx_byte  = rx_shift_r;
  assign rx_valid = rx_valid_r;
  assign rx_err   = rx_err_r;
  assign ser_tx   = ser_tx_r;
  assign tx_ready = tx_ready_s;
  assign tx_done  = tx_end_s;

  // RX line synchroniser and state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_sync_r  <= 2'b11;
      rx_state_r <= RX_IDLE;
    end else begin
      rx_sync_r  <= {rx_sync_r[0], ser_rx};
      rx_state_r <= rx_state_nxt_s;
    end
  end

  // RX next-state: a low stop bit parks in RX_BREAK until the line is released.
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE: begin
        if (!rx_line_s) rx_state_nxt_s = RX_START;
        else            rx_state_nxt_s = RX_IDLE;
      end
      RX_START: begin
        if (rx_half_hit_s) rx_state_nxt_s = rx_line_s ? RX_IDLE : RX_DATA;
        else               rx_state_nxt_s = RX_START;
      end
      RX_DATA: begin
        if (rx_full_hit_s && (rx_bit_r == 3'd7)) rx_state_nxt_s = RX_STOP;
        else                                     rx_state_nxt_s = RX_DATA;
      end
      RX_STOP: begin
        if (rx_full_hit_s) rx_state_nxt_s = rx_line_s ? RX_IDLE : RX_BREAK;
        else               rx_state_nxt_s = RX_STOP;
      end
      RX_BREAK: begin
        if (rx_line_s) rx_state_nxt_s = RX_IDLE;
        else           rx_state_nxt_s = RX_BREAK;
      end
      default: rx_state_nxt_s = RX_IDLE;
    endcase
  end

  // RX bit timing, data shift and byte/error strobes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      case (rx_state_r)
        RX_START: rx_cnt_r <= rx_half_hit_s ? 16'd0 : rx_cnt_r + 16'd1;
        RX_DATA: begin
          if (rx_full_hit_s) begin
            rx_cnt_r   <= 16'd0;
            rx_shift_r <= {rx_line_s, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 3'd1;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_full_hit_s) begin
            rx_cnt_r   <= 16'd0;
            rx_valid_r <= rx_line_s;
            rx_err_r   <= !rx_line_s;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        default: begin
          rx_cnt_r <= 16'd0;
          rx_bit_r <= 3'd0;
        end
      endcase
    end
  end

  // TX state register.
  always_ff @(posedge clk) begin
    if (!resetn) tx_state_r <= TX_IDLE;
    else         tx_state_r <= tx_state_nxt_s;
  end

  // TX next-state.
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (tx_load_s) tx_state_nxt_s = TX_SEND;
        else           tx_state_nxt_s = TX_IDLE;
      end
      TX_SEND: begin
        if (tx_end_s) tx_state_nxt_s = tx_load_s ? TX_SEND : TX_IDLE;
        else          tx_state_nxt_s = TX_SEND;
      end
      default: tx_state_nxt_s = TX_IDLE;
    endcase
  end

  // TX serialiser: start bit on load, then 8 data bits and the stop bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ser_tx_r   <= 1'b1;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 4'd0;
      tx_shift_r <= 9'h1FF;
    end else if (tx_load_s) begin
      ser_tx_r   <= 1'b0;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 4'd0;
      tx_shift_r <= {1'b1, tx_byte};
    end else if (tx_state_r == TX_SEND) begin
      if (tx_full_hit_s) begin
        tx_cnt_r   <= 16'd0;
        tx_bit_r   <= tx_bit_r + 4'd1;
        ser_tx_r   <= tx_end_s ? 1'b1 : tx_shift_r[0];
        tx_shift_r <= {1'b1, tx_shift_r[8:1]};
      end else begin
        tx_cnt_r <= tx_cnt_r + 16'd1;
      end
    end else begin
      ser_tx_r <= 1'b1;
      tx_cnt_r <= 16'd0;
      tx_bit_r <= 4'd0;
    end
  end

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART-to-bus debug bridge: decodes A5 (write) / 5A (read) host frames and issues one bus word access.
// Address and data are assembled little-endian straight into the bus output registers.
module uart_dbg_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = 104,
  parameter int unsigned GAP_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        frame_err
);

  localparam logic [31:0] GAP_LIMIT = 32'(GAP_TIMEOUT);

  bridge_state_e state_r;
  bridge_state_e state_nxt_s;
  logic [1:0]    byte_cnt_r;
  logic          is_write_r;
  logic [31:0]   gap_cnt_r;
  logic [31:0]   rdata_r;
  logic [1:0]    resp_idx_r;
  logic          resp_all_r;
  logic          mem_valid_r;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_wdata_r;
  logic [3:0]    mem_wstrb_r;
  logic          busy_r;
  logic          frame_err_r;

  logic [7:0]    rx_byte_s;
  logic          rx_valid_s;
  logic          rx_err_s;
  logic [7:0]    tx_byte_s;
  logic          tx_valid_s;
  logic          tx_ready_s;
  logic          tx_done_s;
  logic          in_frame_s;
  logic          gap_hit_s;
  logic          is_cmd_s;

  assign in_frame_s = (state_r == ST_ADDR) || (state_r == ST_WDATA);
  assign gap_hit_s  = in_frame_s && (gap_cnt_r >= GAP_LIMIT);
  assign is_cmd_s   = (rx_byte_s == CMD_WRITE) || (rx_byte_s == CMD_READ);

  assign mem_valid = mem_valid_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wstrb = mem_wstrb_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;

  dbg_uart_phy #(
    .BAUD_DIV (BAUD_DIV)
  ) u_phy (
    .clk      (clk),
    .resetn   (resetn),
    .ser_rx   (ser_rx),
    .ser_tx   (ser_tx),
    .rx_byte  (rx_byte_s),
    .rx_valid (rx_valid_s),
    .rx_err   (rx_err_s),
    .tx_byte  (tx_byte_s),
    .tx_valid (tx_valid_s),
    .tx_ready (tx_ready_s),
    .tx_done  (tx_done_s)
  );

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state_r <= ST_IDLE;
    else         state_r <= state_nxt_s;
  end

  // Frame FSM next-state; RX errors outside a frame never disturb BUS/RESP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid_s && is_cmd_s) state_nxt_s = ST_ADDR;
        else                        state_nxt_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (rx_err_s || gap_hit_s)                    state_nxt_s = ST_IDLE;
        else if (rx_valid_s && (byte_cnt_r == 2'd3)) state_nxt_s = is_write_r ? ST_WDATA : ST_BUS;
        else                                          state_nxt_s = ST_ADDR;
      end
      ST_WDATA: begin
        if (rx_err_s || gap_hit_s)                    state_nxt_s = ST_IDLE;
        else if (rx_valid_s && (byte_cnt_r == 2'd3)) state_nxt_s = ST_BUS;
        else                                          state_nxt_s = ST_WDATA;
      end
      ST_BUS: begin
        if (mem_valid_r && mem_ready) state_nxt_s = ST_RESP;
        else                          state_nxt_s = ST_BUS;
      end
      ST_RESP: begin
        if (resp_all_r && tx_done_s) state_nxt_s = ST_IDLE;
        else                         state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Response byte offered to the TX engine.
  always_comb begin
    tx_valid_s = 1'b0;
    tx_byte_s  = 8'd0;
    if ((state_r == ST_RESP) && !resp_all_r) begin
      tx_valid_s = 1'b1;
      tx_byte_s  = is_write_r ? ACK_CODE : byte_sel(rdata_r, resp_idx_r);
    end else begin
      tx_valid_s = 1'b0;
      tx_byte_s  = 8'd0;
    end
  end

  // Frame assembly, gap counter, bus handshake and response sequencing.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      byte_cnt_r  <= 2'd0;
      is_write_r  <= 1'b0;
      gap_cnt_r   <= 32'd0;
      rdata_r     <= 32'd0;
      resp_idx_r  <= 2'd0;
      resp_all_r  <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_wstrb_r <= 4'b0000;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= rx_err_s || gap_hit_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      gap_cnt_r   <= (in_frame_s && !rx_valid_s) ? gap_cnt_r + 32'd1 : 32'd0;

      if ((state_r != ST_BUS) && (state_nxt_s == ST_BUS)) begin
        mem_valid_r <= 1'b1;
        mem_wstrb_r <= is_write_r ? 4'b1111 : 4'b0000;
      end

      case (state_r)
        ST_IDLE: begin
          byte_cnt_r <= 2'd0;
          resp_idx_r <= 2'd0;
          resp_all_r <= 1'b0;
          if (rx_valid_s && is_cmd_s) begin
            is_write_r  <= (rx_byte_s == CMD_WRITE);
            mem_wdata_r <= 32'd0;
          end
        end
        ST_ADDR: begin
          if (rx_valid_s && !gap_hit_s) begin
            mem_addr_r <= {rx_byte_s, mem_addr_r[31:8]};
            byte_cnt_r <= byte_cnt_r + 2'd1;
          end
        end
        ST_WDATA: begin
          if (rx_valid_s && !gap_hit_s) begin
            mem_wdata_r <= {rx_byte_s, mem_wdata_r[31:8]};
            byte_cnt_r  <= byte_cnt_r + 2'd1;
          end
        end
        ST_BUS: begin
          if (mem_valid_r && mem_ready) begin
            mem_valid_r <= 1'b0;
            rdata_r     <= mem_rdata;
          end
        end
        ST_RESP: begin
          if (tx_valid_s && tx_ready_s) begin
            resp_idx_r <= resp_idx_r + 2'd1;
            if (is_write_r || (resp_idx_r == 2'd3)) resp_all_r <= 1'b1;
          end
        end
        default: byte_cnt_r <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Self-checking bench for uart_dbg_bridge: directed scenarios plus randomized frames
// checked against a frame-level reference (expected bus word and response bytes).
module tb_uart_dbg_bridge;

  localparam int BD  = 8;
  localparam int GAP = 200;

  logic        clk;
  logic        resetn;
  logic        ser_rx;
  logic        ser_tx;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0]  tx_q[$];
  int          tx_start[$];
  logic [7:0]  rcv_b;
  int          rcv_st;

  int          bus_cnt = 0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  int          ready_dly = 3;
  logic [31:0] cur_rdata = 32'd0;
  int          spur_req = 0;
  int          spur_done = 0;

  int          ferr_pulses = 0;
  int          ferr_cycles = 0;
  bit          ferr_prev = 1'b0;

  uart_dbg_bridge #(
    .BAUD_DIV    (BD),
    .GAP_TIMEOUT (GAP)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ser_rx    (ser_rx),
    .ser_tx    (ser_tx),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .frame_err (frame_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  // frame_err pulse monitor
  initial begin
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        ferr_cycles++;
        if (!ferr_prev) ferr_pulses++;
      end
      ferr_prev = (frame_err === 1'b1);
    end
  end

  // UART receiver on ser_tx, samples mid-bit
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && ser_tx === 1'b0) begin
        rcv_st = cyc;
        repeat (BD / 2 - 1) @(negedge clk);
        check_val("tx_start_bit", {31'd0, ser_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          rcv_b[i] = ser_tx;
        end
        repeat (BD) @(negedge clk);
        check_val("tx_stop_bit", {31'd0, ser_tx}, 32'd1);
        tx_q.push_back(rcv_b);
        tx_start.push_back(rcv_st);
      end
    end
  end

  // bus responder and monitor
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (spur_req != spur_done) begin
        if (mem_valid === 1'b0) begin
          mem_ready = 1'b1;
          @(negedge clk);
          mem_ready = 1'b0;
        end
        spur_done = spur_req;
      end else if (mem_valid === 1'b1 && ready_dly >= 0) begin
        bus_cnt++;
        bus_addr  = mem_addr;
        bus_wdata = mem_wdata;
        bus_wstrb = mem_wstrb;
        for (int i = 0; i < ready_dly; i++) begin
          @(negedge clk);
          check_val("bus_hold_valid", {31'd0, mem_valid}, 32'd1);
          check_val("bus_hold_addr", mem_addr, bus_addr);
          check_val("bus_hold_wdata", mem_wdata, bus_wdata);
          check_val("bus_hold_wstrb", {28'd0, mem_wstrb}, {28'd0, bus_wstrb});
        end
        mem_rdata = cur_rdata;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = $urandom();
        check_val("bus_valid_drop", {31'd0, mem_valid}, 32'd0);
      end
    end
  end

  task automatic uart_send(input logic [7:0] b, input bit bad_stop);
    @(posedge clk); #1;
    ser_rx = 1'b0;
    repeat (BD) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (BD) @(posedge clk); #1;
    end
    ser_rx = bad_stop ? 1'b0 : 1'b1;
    repeat (BD) @(posedge clk); #1;
    ser_rx = 1'b1;
  endtask

  task automatic send_frame(input bit is_wr, input logic [31:0] addr, input logic [31:0] data);
    uart_send(is_wr ? 8'hA5 : 8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) uart_send(8'((addr >> (8 * i)) & 32'hFF), 1'b0);
    if (is_wr) begin
      for (int i = 0; i < 4; i++) uart_send(8'((data >> (8 * i)) & 32'hFF), 1'b0);
    end
  endtask

  task automatic run_frame(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input int dly, input int junk);
    logic [7:0] exp_tx[$];
    logic [7:0] jb;
    int bus0, ferr0, t;
    bus0      = bus_cnt;
    ferr0     = ferr_pulses;
    ready_dly = dly;
    cur_rdata = rdata;
    tx_q.delete();
    tx_start.delete();
    for (int j = 0; j < junk; j++) begin
      do jb = 8'($urandom_range(0, 255)); while (jb == 8'hA5 || jb == 8'h5A);
      uart_send(jb, 1'b0);
    end
    send_frame(is_wr, addr, data);
    if (is_wr) exp_tx.push_back(8'h06);
    else for (int i = 0; i < 4; i++) exp_tx.push_back(8'((rdata >> (8 * i)) & 32'hFF));
    t = 0;
    while (t < 2000 && !(tx_q.size() >= exp_tx.size() && busy === 1'b0)) begin
      @(negedge clk);
      t++;
    end
    check_val("bus_count", bus_cnt, bus0 + 1);
    check_val("bus_addr", bus_addr, addr);
    check_val("bus_wstrb", {28'd0, bus_wstrb}, is_wr ? 32'hF : 32'h0);
    if (is_wr) check_val("bus_wdata", bus_wdata, data);
    check_val("tx_count", tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) begin
      check_val($sformatf("tx_byte%0d", i), (tx_q.size() > i) ? {24'd0, tx_q[i]} : 32'hFFFF_FFFF,
                {24'd0, exp_tx[i]});
      if (i > 0 && tx_start.size() > i)
        check_val("tx_back_to_back", tx_start[i] - tx_start[i-1], 10 * BD);
    end
    check_val("resp_idle", {31'd0, busy}, 32'd0);
    check_val("frame_no_err", ferr_pulses, ferr0);
  endtask

  initial begin
    int ferr0, bus0, t;
    resetn = 1'b0;
    ser_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_ser_tx", {31'd0, ser_tx}, 32'd1);
    check_val("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    check_val("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // stray mem_ready while idle
    spur_req++;
    repeat (6) @(negedge clk);
    check_val("spur_busy", {31'd0, busy}, 32'd0);
    check_val("spur_bus", bus_cnt, 0);

    // directed write and read
    run_frame(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 32'h0, 3, 0);
    run_frame(1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 2, 0);

    // bad stop bit on the 3rd address byte
    ferr0 = ferr_pulses;
    bus0  = bus_cnt;
    uart_send(8'h5A, 1'b0);
    uart_send(8'h04, 1'b0);
    uart_send(8'h00, 1'b0);
    uart_send(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    check_val("badstop_ferr", ferr_pulses, ferr0 + 1);
    check_val("badstop_idle", {31'd0, busy}, 32'd0);
    check_val("badstop_nobus", bus_cnt, bus0);
    run_frame(1'b0, 32'h0000_0100, 32'h0, 32'hA1B2_C3D4, 1, 0);

    // inter-byte gap timeout
    ferr0 = ferr_pulses;
    bus0  = bus_cnt;
    uart_send(8'hA5, 1'b0);
    uart_send(8'h11, 1'b0);
    uart_send(8'h22, 1'b0);
    repeat (190) @(negedge clk);
    check_val("gap_early", ferr_pulses, ferr0);
    check_val("gap_busy_early", {31'd0, busy}, 32'd1);
    repeat (11) @(negedge clk);
    repeat (4) @(negedge clk);
    check_val("gap_ferr", ferr_pulses, ferr0 + 1);
    check_val("gap_idle", {31'd0, busy}, 32'd0);
    check_val("gap_nobus", bus_cnt, bus0);

    // junk in idle then a valid write
    ferr0 = ferr_pulses;
    bus0  = bus_cnt;
    uart_send(8'h00, 1'b0);
    uart_send(8'hFF, 1'b0);
    run_frame(1'b1, 32'hCAFE_0000, 32'h0BAD_F00D, 32'h0, 0, 0);
    check_val("junk_ferr", ferr_pulses, ferr0);
    check_val("junk_one_bus", bus_cnt, bus0 + 1);

    // randomized frames
    for (int k = 0; k < 8; k++)
      run_frame(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(),
                $urandom_range(0, 5), $urandom_range(0, 2));

    // reset during an unanswered bus cycle
    ready_dly = -1;
    tx_q.delete();
    send_frame(1'b1, 32'h0000_0040, 32'h5555_AAAA);
    t = 0;
    while (t < 50 && mem_valid !== 1'b1) begin
      @(negedge clk);
      t++;
    end
    check_val("hang_valid", {31'd0, mem_valid}, 32'd1);
    repeat (40) @(negedge clk);
    check_val("hang_still_valid", {31'd0, mem_valid}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check_val("midrst_valid", {31'd0, mem_valid}, 32'd0);
    check_val("midrst_ser_tx", {31'd0, ser_tx}, 32'd1);
    resetn = 1'b1;
    ready_dly = 3;
    repeat (12 * BD) @(negedge clk);
    check_val("midrst_no_resp", tx_q.size(), 0);
    check_val("midrst_idle", {31'd0, busy}, 32'd0);
    run_frame(1'b0, 32'h0000_0040, 32'h0, 32'h0F1E_2D3C, 4, 0);

    check_val("ferr_one_cycle", ferr_cycles, ferr_pulses);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
